// File: rtl/flag_pkg.sv
`default_nettype none
// =============================================================================
// flag_pkg : FLAGS bit positions, writable mask, flag-control ops, Jcc codes
// Revision : 1.0
// =============================================================================
package flag_pkg;

    localparam int CF_B = 0;
    localparam int PF_B = 2;
    localparam int AF_B = 4;
    localparam int ZF_B = 6;
    localparam int SF_B = 7;
    localparam int TF_B = 8;
    localparam int IF_B = 9;
    localparam int DF_B = 10;
    localparam int OF_B = 11;

    localparam logic [15:0] WRITABLE_MASK = 16'h0FD5;
    localparam logic [15:0] TRAP_CLR_MASK = 16'h0300;

    typedef enum logic [2:0] {
        FOP_NOP = 3'd0,
        FOP_CLC = 3'd1,
        FOP_STC = 3'd2,
        FOP_CMC = 3'd3,
        FOP_CLD = 3'd4,
        FOP_STD = 3'd5,
        FOP_CLI = 3'd6,
        FOP_STI = 3'd7
    } flag_op_e;

    typedef enum logic [3:0] {
        CC_O  = 4'h0, CC_NO = 4'h1, CC_B  = 4'h2, CC_AE = 4'h3,
        CC_E  = 4'h4, CC_NE = 4'h5, CC_BE = 4'h6, CC_A  = 4'h7,
        CC_S  = 4'h8, CC_NS = 4'h9, CC_P  = 4'hA, CC_NP = 4'hB,
        CC_L  = 4'hC, CC_GE = 4'hD, CC_LE = 4'hE, CC_G  = 4'hF
    } cond_code_e;

    typedef enum logic [0:0] {
        TRAP_IDLE = 1'b0,
        TRAP_PEND = 1'b1
    } trap_state_e;

endpackage
`default_nettype wire

// File: rtl/flag_cond_eval.sv
`default_nettype none
// =============================================================================
// flag_cond_eval : combinational Jcc predicate; odd codes negate the even one
// Revision : 1.0
// =============================================================================
module flag_cond_eval
    import flag_pkg::*;
(
    input  logic [15:0] flags,
    input  logic [3:0]  cond_code,
    output logic        taken
);

    logic w_base;
    logic w_unused;

    assign w_unused = ^{flags[15:12], flags[10:8], flags[5:3], flags[1]};

    always_comb begin
        w_base = 1'b0;
        case (cond_code[3:1])
            3'd0: w_base = flags[OF_B];
            3'd1: w_base = flags[CF_B];
            3'd2: w_base = flags[ZF_B];
            3'd3: w_base = flags[CF_B] | flags[ZF_B];
            3'd4: w_base = flags[SF_B];
            3'd5: w_base = flags[PF_B];
            3'd6: w_base = flags[SF_B] ^ flags[OF_B];
            3'd7: w_base = flags[ZF_B] | (flags[SF_B] ^ flags[OF_B]);
            default: w_base = 1'b0;
        endcase
    end

    assign taken = w_base ^ cond_code[0];

endmodule
`default_nettype wire

// File: rtl/flag_reg_unit.sv
`default_nettype none
// =============================================================================
// flag_reg_unit : architectural FLAGS register, single-step trap FSM, Jcc eval
// Revision : 1.0
// =============================================================================
module flag_reg_unit
    import flag_pkg::*;
#(
    parameter logic [15:0] RESET_FLAGS = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] alu_flag,
    input  logic        alu_we,
    input  logic [15:0] alu_mask,
    input  logic [15:0] bus_data,
    input  logic        bus_we,
    input  logic [2:0]  flag_op,
    input  logic        cond_req,
    input  logic [3:0]  cond_code,
    output logic        cond_valid,
    output logic        cond_taken,
    input  logic        instr_done,
    output logic        trap_req,
    input  logic        trap_ack,
    output logic [15:0] flags
);

    localparam logic [0:0] ST_IDLE = TRAP_IDLE;
    localparam logic [0:0] ST_PEND = TRAP_PEND;

    logic [15:0] flags_q, flags_d;
    logic [0:0]  state_q, state_d;
    logic        cond_valid_q, cond_taken_q;
    logic        w_trap_entry;
    logic        w_taken;
    logic [15:0] w_alu_m;

    assign w_trap_entry = (state_q == ST_PEND) && trap_ack;
    assign w_alu_m      = alu_mask & WRITABLE_MASK;

    // Single winner per cycle; lower-priority sources are dropped, not merged.
    always_comb begin
        flags_d = flags_q;
        if (w_trap_entry) begin
            flags_d = flags_q & ~TRAP_CLR_MASK;
        end else if (bus_we) begin
            flags_d = bus_data;
        end else if (alu_we) begin
            flags_d = (flags_q & ~w_alu_m) | (alu_flag & w_alu_m);
        end else begin
            case (flag_op_e'(flag_op))
                FOP_CLC: flags_d[CF_B] = 1'b0;
                FOP_STC: flags_d[CF_B] = 1'b1;
                FOP_CMC: flags_d[CF_B] = ~flags_q[CF_B];
                FOP_CLD: flags_d[DF_B] = 1'b0;
                FOP_STD: flags_d[DF_B] = 1'b1;
                FOP_CLI: flags_d[IF_B] = 1'b0;
                FOP_STI: flags_d[IF_B] = 1'b1;
                default: flags_d = flags_q;
            endcase
        end
        flags_d = flags_d & WRITABLE_MASK;
    end

    // TF is taken from the registered value so a POPF setting TF cannot trap on its own retire.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (instr_done && flags_q[TF_B]) state_d = ST_PEND;
            ST_PEND: if (trap_ack) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    flag_cond_eval u_cond_eval (
        .flags     (flags_d),
        .cond_code (cond_code),
        .taken     (w_taken)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags_q      <= RESET_FLAGS & WRITABLE_MASK;
            state_q      <= ST_IDLE;
            cond_valid_q <= 1'b0;
            cond_taken_q <= 1'b0;
        end else begin
            flags_q      <= flags_d;
            state_q      <= state_d;
            cond_valid_q <= cond_req;
            cond_taken_q <= cond_req & w_taken;
        end
    end

    assign flags      = flags_q;
    assign trap_req   = (state_q == ST_PEND);
    assign cond_valid = cond_valid_q;
    assign cond_taken = cond_taken_q;

endmodule
`default_nettype wire

// File: doc/flag_reg_unit.md
# flag_reg_unit

Architectural FLAGS register and its consumer side. Latches the 16-bit flag words produced by the ALU flag generator, applies flag-control instructions, POPF loads and the single-step trap sequence, and evaluates the 16 conditional-jump predicates for the branch unit. Sits between the ALU/flag generator (producer) and the sequencer/branch logic (consumers).

## Interface
- RESET_FLAGS, 16'h0000, FLAGS value loaded on reset (non-writable bits forced to 0)
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- alu_flag  in  16  flag word from the flag generator, standard layout: CF0 PF2 AF4 ZF6 SF7 TF8 IF9 DF10 OF11
- alu_we  in  1  commit alu_flag bits selected by alu_mask
- alu_mask  in  16  per-bit update enable for alu_we
- bus_data  in  16  POPF source word
- bus_we  in  1  load all writable bits from bus_data
- flag_op  in  3  0 NOP, 1 CLC, 2 STC, 3 CMC, 4 CLD, 5 STD, 6 CLI, 7 STI
- cond_req  in  1  condition evaluation request
- cond_code  in  4  Jcc low nibble (0 O … F G)
- cond_valid  out  1  one-cycle pulse, result available
- cond_taken  out  1  predicate result, qualified by cond_valid
- instr_done  in  1  one-cycle pulse at instruction retire
- trap_req  out  1  single-step trap request, held until acknowledged
- trap_ack  in  1  sequencer accepts trap
- flags  out  16  current FLAGS register

## Operation
- Writable mask 16'h0FD5 (CF PF AF ZF SF TF IF DF OF); other bits always read 0, any write to them ignored.
- Next-value priority per cycle: trap entry > bus_we > alu_we > flag_op. Lower-priority sources in the same cycle are discarded entirely (no merging).
- alu_we: flags_n = (flags & ~m) | (alu_flag & m), m = alu_mask & 16'h0FD5.
- bus_we: flags_n = bus_data & 16'h0FD5.
- flag_op: CLC/STC/CMC act on CF, CLD/STD on DF, CLI/STI on IF; other bits unchanged.
- Conditions: 0 OF, 1 !OF, 2 CF, 3 !CF, 4 ZF, 5 !ZF, 6 CF|ZF, 7 !(CF|ZF), 8 SF, 9 !SF, A PF, B !PF, C SF^OF, D !(SF^OF), E ZF|(SF^OF), F !(ZF|(SF^OF)).
- Condition is evaluated against flags_n (forwarded next value) of the request cycle, so a request in the same cycle as a flag update sees the update.
- Trap FSM, states IDLE, PEND:
  - IDLE→PEND on instr_done when TF=1 at that cycle's start; trap_req=1 in PEND.
  - PEND→IDLE on trap_ack; that same edge clears TF and IF (trap entry, highest priority).
  - instr_done in PEND ignored; trap_ack in IDLE ignored.
  - An instruction that sets TF (POPF) does not trap on its own retire: TF sampled pre-update.

## Timing
- Reset (async assert): flags=RESET_FLAGS&16'h0FD5, cond_valid=0, cond_taken=0, trap_req=0, FSM=IDLE. Deassertion is synchronous to clk by upstream logic.
- Flag update latency 1: write at edge N visible on flags after edge N.
- Condition latency 1: cond_req at cycle N → cond_valid/cond_taken registered at N+1. Back-to-back requests every cycle supported; no backpressure.
- trap_req rises the cycle after instr_done; falls the cycle after trap_ack.
- Reset mid-trap or mid-request: pending trap and cond_valid dropped, no late pulse.

## Structure
- Package flag_pkg: bit index constants (CF_B…OF_B), WRITABLE_MASK, flag_op enum, cond_code enum, trap state enum.
- One combinational sub-module flag_cond_eval (flags[15:0], cond_code → taken), reused by the branch unit.

## Test plan
- Reset with RESET_FLAGS=16'hFFFF → flags=16'h0FD5, trap_req=0, cond_valid=0.
- alu_flag=16'h0041, alu_mask=16'h00C5, alu_we from flags=16'h0080 → flags=16'h0041; same cycle flag_op=STC → ignored, CF from ALU.
- bus_we=1 bus_data=16'hFFFF with alu_we=1 same cycle → flags=16'h0FD5.
- flags=16'h0800 (OF), cond_req code C in same cycle as alu_we setting SF (mask 16'h0080, data 16'h0080) → next cycle cond_valid=1, cond_taken=0 (SF^OF=0).
- TF=1, IF=1, instr_done → trap_req=1 next cycle; second instr_done ignored; trap_ack → trap_req=0, TF=0, IF=0 next cycle.
- POPF setting TF coincident with instr_done → no trap; next instr_done → trap_req=1.
